// File: rtl/card_pkg.sv
// card_pkg
// Shared constants and types for the card sprite blitter.
//   CARD_W x CARD_H : sprite geometry (16 x 32, row-major, 512 pixels)
//   SCREEN_W x SCREEN_H : frame-buffer geometry (256 x 240)
//   card_addr_t / fb_addr_t / pixel_t : bus types for the two memories
//   blit_state_e : blit sequencer states
package card_pkg;

  localparam int CARD_W   = 16;
  localparam int CARD_H   = 32;
  localparam int CARD_N   = CARD_W * CARD_H;
  localparam int SCREEN_W = 256;
  localparam int SCREEN_H = 240;

  typedef logic [8:0]  card_addr_t;
  typedef logic [15:0] fb_addr_t;
  typedef logic [2:0]  pixel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } blit_state_e;

  // Screen-space coordinates are 9 bits wide so that an overflow past the
  // right or bottom edge is visible instead of wrapping.
  function automatic logic on_screen(input logic [8:0] px, input logic [8:0] py);
    return (px < 9'(SCREEN_W)) && (py < 9'(SCREEN_H));
  endfunction

endpackage

// File: rtl/card_blit_ctrl.sv
// card_blit_ctrl
// Copies one full 16x32 card sprite from the card RAM into the 256x240
// frame buffer with its top-left pixel at (x0, y0), clipping anything that
// lands off-screen.
//
// Ports
//   clock, reset_n         : rising-edge clock, async active-low reset
//   start, x0, y0          : blit request and origin (sampled in IDLE only)
//   busy, done             : busy during FETCH/DRAIN, one-cycle done in FIN
//   card_re, card_raddr    : card RAM read port (1-cycle read latency)
//   card_data              : card RAM read data
//   fb_we, fb_addr, fb_data: frame-buffer write port, addr = row*256 + col
//
// Build option
//   CARD_BLIT_TRANSPARENT_EN : when defined, colour 0 is transparent and is
//                              never written. Timing is unchanged.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; origin latched on acceptance
// FETCH | one card RAM read per cycle, idx 0..511
// DRAIN | write stage finishes the pixel read in the last FETCH cycle
// FIN   | done pulse, back to IDLE
module card_blit_ctrl
  import card_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] x0,
  input  logic [7:0] y0,
  output logic       busy,
  output logic       done,
  output logic       card_re,
  output card_addr_t card_raddr,
  input  pixel_t     card_data,
  output logic       fb_we,
  output fb_addr_t   fb_addr,
  output pixel_t     fb_data
);

  blit_state_e state;
  card_addr_t  idx;
  logic [7:0]  x0_q;
  logic [7:0]  y0_q;
  logic        wr_valid;
  logic        wr_inb;

  logic [8:0]  px;
  logic [8:0]  py;

  // Screen position of the pixel being read this cycle; it is registered
  // into the write stage so it lines up with card_data one cycle later.
  always_comb begin
    px = {1'b0, x0_q} + {5'b0, idx[3:0]};
    py = {1'b0, y0_q} + {4'b0, idx[8:4]};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      card_re  <= 1'b0;
      idx      <= '0;
      x0_q     <= '0;
      y0_q     <= '0;
      wr_valid <= 1'b0;
      wr_inb   <= 1'b0;
      fb_addr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            x0_q    <= x0;
            y0_q    <= y0;
            idx     <= '0;
            card_re <= 1'b1;
            busy    <= 1'b1;
            state   <= FETCH;
          end
        end
        FETCH: begin
          wr_valid <= 1'b1;
          wr_inb   <= on_screen(px, py);
          fb_addr  <= {py[7:0], px[7:0]};
          if (idx == card_addr_t'(CARD_N - 1)) begin
            card_re <= 1'b0;
            state   <= DRAIN;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DRAIN: begin
          wr_valid <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b1;
          state    <= FIN;
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign card_raddr = idx;

  // Read data only exists in the write cycle, so the data path and the
  // enable are combinational on card_data, qualified by the registered
  // write-stage valid (which also forces both to 0 while in reset).
  assign fb_data = wr_valid ? card_data : '0;

`ifdef CARD_BLIT_TRANSPARENT_EN
  assign fb_we = wr_valid && wr_inb && (card_data != '0);
`else
  assign fb_we = wr_valid && wr_inb;
`endif

endmodule

// File: doc/card_blit_ctrl.md
Name: card_blit_ctrl

Overview:
- Sequences one full read sweep of a 512 x 3-bit card sprite RAM (16 wide x 32 tall, row-major, 1-cycle registered read latency).
- Writes each fetched pixel into the 256x240 frame buffer at a requested screen origin.
- Sits between the game/draw logic (start/done handshake) and the card RAM read port plus the frame-buffer write port.
- Clips pixels falling off-screen.

Parameters:
- CARD_W, 16, sprite width in pixels; power of two.
- CARD_H, 32, sprite height in pixels; CARD_W*CARD_H = 512.
- SCREEN_W, 256, frame-buffer width; power of two.
- SCREEN_H, 240, visible frame-buffer height.

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  request a blit; sampled only in IDLE
- x0  in  8  screen column of sprite top-left pixel
- y0  in  8  screen row of sprite top-left pixel
- busy  out  1  high while a blit is in progress
- done  out  1  one-cycle pulse when a blit completes
- card_re  out  1  card RAM read enable
- card_raddr  out  9  card RAM read address
- card_data  in  3  card RAM read data, valid the cycle after card_re
- fb_we  out  1  frame-buffer write enable
- fb_addr  out  16  frame-buffer address = row*256 + col
- fb_data  out  3  frame-buffer pixel colour

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; busy=0, done=0, card_re=0, card_raddr=0, fb_we=0, fb_addr=0, fb_data=0.
  - Latched origin and index counter cleared.
  - Reset asserted mid-blit aborts immediately. No further RAM reads or FB writes occur; the partial image is left as-is.
- States:
  - IDLE: done=0. On start=1, latch x0/y0, clear idx, go to FETCH.
  - FETCH: drive card_re=1, card_raddr=idx; idx++ each cycle. After issuing idx=511, go to DRAIN.
  - DRAIN: one cycle to write the final pixel, then go to FIN.
  - FIN: done=1 for exactly one cycle, then go to IDLE.
- busy=1 in FETCH and DRAIN, 0 otherwise.
- Start handling:
  - start is ignored while busy or in FIN; no queuing.
  - start held high continuously re-triggers a new blit each time IDLE is reached.
- Pipeline:
  - Write stage uses the index and origin registered one cycle behind the read stage.
  - For index k issued in cycle t, the FB write occurs in cycle t+1: col=k[3:0], row=k[8:4].
- Address arithmetic:
  - px = {1'b0,x0}+col (9 bits); py = {1'b0,y0}+row (9 bits).
  - fb_addr = {py[7:0], px[7:0]}.
- Clipping:
  - fb_we=0 when px>=256 or py>=240; no wrap-around onto the next row or to the top.
  - fb_addr/fb_data still update but are don't-care when fb_we=0.
- Latency: start accepted in cycle T → first read T+1, first write T+2, last write T+513, done pulse T+514. 512 reads total.
- card_re is never asserted outside FETCH. fb_we is never asserted outside the write stage.
- Origin inputs are not re-sampled during a blit; changes to x0/y0 mid-blit have no effect.

Optional Feature:
- Macro: CARD_BLIT_TRANSPARENT_EN.
- Defined: pixels with card_data==3'b000 are transparent. fb_we is held 0 for them in addition to clipping, so the background is preserved.
- Undefined: colour 0 is written like any other colour.
- Timing and done position are identical in both builds.

Decomposition:
- Shared package card_pkg:
  - CARD_W/CARD_H/SCREEN_W/SCREEN_H constants
  - card_addr_t (9-bit), fb_addr_t (16-bit), pixel_t (3-bit)
  - blit_state_e enum {IDLE, FETCH, DRAIN, FIN}
- Single module; no sub-module needed. Address/clip logic stays inline as the write stage.

Test Plan:
- Reset mid-blit: start at (0,0), drop reset_n at idx=100 → all outputs 0 asynchronously, no fb_we after release, next start performs a full blit.
- Origin (0,0), RAM preloaded with k%8 → 512 writes, fb_addr for k=17 is 0x0101 with data 1; done pulses exactly 514 cycles after start sampled.
- Right-edge clip, origin (248,0) → only cols 0-7 written per row (256 writes); no write to fb_addr 0x0100 from col 8 of row 0.
- Bottom clip, origin (0,220) → rows 0-19 written (320 writes), none with py>=240; done timing unchanged.
- start pulsed again at T+5 and T+514, start held high → both ignored; held start triggers next blit at T+516 (FIN→IDLE→FETCH).
- Transparent build, RAM all 0 except index 0=3'b101 → exactly one write, fb_addr={y0,x0}, data 5; non-transparent build → 512 writes.
